// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error evaluator.
package adder_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mismatch counter must hold 2^n_in itself, hence one extra bit.
  function automatic int err_cnt_width(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int sum_width(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  localparam int DEF_N_IN  = 8;
  localparam int DEF_N_OUT = 5;
  localparam int ERR_CNT_W = err_cnt_width(DEF_N_IN);
  localparam int SUM_W     = sum_width(DEF_N_IN, DEF_N_OUT);

endpackage

// File: rtl/adder_err_eval_if.sv
// Evaluator bus: control handshake, stimulus/response to the adder under test,
// and the metric outputs. First-fail signals exist only with ADDER_ERR_FIRST_FAIL_EN.
interface adder_err_eval_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 5
);
  logic                                              start;
  logic                                              busy;
  logic                                              done;
  logic [N_IN-1:0]                                   vec_o;
  logic [N_OUT-1:0]                                  approx_i;
  logic [adder_eval_pkg::err_cnt_width(N_IN)-1:0]    err_cnt;
  logic [N_OUT-1:0]                                  max_err;
  logic [adder_eval_pkg::sum_width(N_IN, N_OUT)-1:0] sum_err;
  logic                                              pass;
`ifdef ADDER_ERR_FIRST_FAIL_EN
  logic                                              first_fail_vld;
  logic [N_IN-1:0]                                   first_fail_vec;
`endif

  modport master (
    input  start, approx_i,
    output busy, done, vec_o, err_cnt, max_err, sum_err, pass
`ifdef ADDER_ERR_FIRST_FAIL_EN
    , output first_fail_vld, first_fail_vec
`endif
  );

  modport slave (
    output start, approx_i,
    input  busy, done, vec_o, err_cnt, max_err, sum_err, pass
`ifdef ADDER_ERR_FIRST_FAIL_EN
    , input first_fail_vld, first_fail_vec
`endif
  );
endinterface

// File: rtl/adder_err_acc.sv
// Registered compare stage plus error accumulators for one sweep.
// Optional first-fail capture is enabled by ADDER_ERR_FIRST_FAIL_EN.
module adder_err_acc
  import adder_eval_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                cap_en,
  input  logic [N_IN-1:0]                     vec,
  input  logic [N_OUT-1:0]                    approx,
  output logic [err_cnt_width(N_IN)-1:0]      err_cnt,
  output logic [N_OUT-1:0]                    max_err,
  output logic [sum_width(N_IN, N_OUT)-1:0]   sum_err
`ifdef ADDER_ERR_FIRST_FAIL_EN
  ,
  output logic                                first_fail_vld,
  output logic [N_IN-1:0]                     first_fail_vec
`endif
);

  localparam int CW   = err_cnt_width(N_IN);
  localparam int SW   = sum_width(N_IN, N_OUT);
  localparam int HALF = N_IN / 2;

  logic              cap_vld;
  logic [N_IN-1:0]   cap_vec;
  logic [N_OUT-1:0]  cap_approx;

  logic [N_OUT-1:0]  exact;
  logic signed [N_OUT:0] delta;
  logic signed [N_OUT:0] abs_delta;
  logic [N_OUT-1:0]  diff;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    exact     = N_OUT'(cap_vec[HALF-1:0]) + N_OUT'(cap_vec[N_IN-1:HALF]);
    delta     = $signed({1'b0, exact}) - $signed({1'b0, cap_approx});
    abs_delta = delta;
    if (delta[N_OUT]) abs_delta = -delta;
    diff      = abs_delta[N_OUT-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld    <= 1'b0;
      cap_vec    <= '0;
      cap_approx <= '0;
      err_cnt    <= '0;
      max_err    <= '0;
      sum_err    <= '0;
    end else if (clear) begin
      cap_vld <= 1'b0;
      err_cnt <= '0;
      max_err <= '0;
      sum_err <= '0;
    end else begin
      cap_vld <= cap_en;
      if (cap_en) begin
        cap_vec    <= vec;
        cap_approx <= approx;
      end
      if (cap_vld) begin
        if (diff != '0) err_cnt <= err_cnt + CW'(1);
        if (diff > max_err) max_err <= diff;
        sum_err <= sum_err + SW'(diff);
      end
    end
  end

`ifdef ADDER_ERR_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (clear) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (cap_vld && diff != '0 && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_vec <= cap_vec;
    end
  end
`endif

endmodule

// File: rtl/adder_err_eval.sv
// Exhaustive error evaluator: sweeps every input vector through an approximate adder.
// Optional first-fail capture is enabled by ADDER_ERR_FIRST_FAIL_EN.
module adder_err_eval
  import adder_eval_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 5,
  parameter int ET    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_err_eval_if.master bus
);

  localparam logic [N_OUT-1:0] ET_W = N_OUT'(ET);

  state_t          state;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            clear;
  logic            cap_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          vec   <= '0;
          busy  <= 1'b1;
        end
        // The last vector holds on vec while its capture drains through the compare stage.
        RUN: if (&vec) state <= DRAIN;
             else      vec   <= vec + N_IN'(1);
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clear  = (state == IDLE) && bus.start;
  assign cap_en = (state == RUN);

  assign bus.vec_o = vec;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.pass  = (bus.max_err <= ET_W);

  adder_err_acc #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_acc (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .cap_en         (cap_en),
    .vec            (vec),
    .approx         (bus.approx_i),
    .err_cnt        (bus.err_cnt),
    .max_err        (bus.max_err),
    .sum_err        (bus.sum_err)
`ifdef ADDER_ERR_FIRST_FAIL_EN
    ,
    .first_fail_vld (bus.first_fail_vld),
    .first_fail_vec (bus.first_fail_vec)
`endif
  );

endmodule
